// File: rtl/segway_pkg.sv
// Shared command codes and state encodings for the BLE receive path of the Segway.
package segway_pkg;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 12-bit down-counting baud timer, LSB-first shifter.
module uart_rx
  import segway_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);

  // Loads are one less than the interval because expiry is the cycle the count reads 0.
  localparam logic [11:0] HALF_LOAD = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] FULL_LOAD = 12'(BAUD_DIV - 1);

  logic        rx_meta_q;
  logic        rx_sync_q;
  logic        rx_prev_q;
  rx_state_t   state_q;
  logic [11:0] cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_rdy_q;
  logic        frm_err_q;

  logic fall_det;
  logic cnt_expired;

  assign fall_det    = rx_prev_q & ~rx_sync_q;
  assign cnt_expired = (cnt_q == 12'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= 12'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rx_rdy_q  <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_rdy_q  <= 1'b0;
      frm_err_q <= 1'b0;
      if (state_q != IDLE && !cnt_expired) begin
        cnt_q <= cnt_q - 12'd1;
      end
      case (state_q)
        IDLE: begin
          if (fall_det) begin
            state_q <= START;
            cnt_q   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt_expired) begin
            if (rx_sync_q) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              cnt_q     <= FULL_LOAD;
              bit_cnt_q <= 3'd0;
            end
          end
        end
        DATA: begin
          if (cnt_expired) begin
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            cnt_q     <= FULL_LOAD;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (cnt_expired) begin
            if (rx_sync_q) begin
              rx_data_q <= shift_q;
              rx_rdy_q  <= 1'b1;
            end else begin
              frm_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;
  assign frm_err = frm_err_q;

endmodule

// File: rtl/ble_auth_rx.sv
// BLE command endpoint: receives UART bytes and turns 'g'/'s' commands into the pwr_up enable.
module ble_auth_rx
  import segway_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  auth_state_t auth_q;
  logic        pwr_up_q;
  logic        go_cmd;
  logic        stop_cmd;

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .rx_data(rx_data),
    .rx_rdy (rx_rdy),
    .frm_err(frm_err)
  );

  assign go_cmd   = rx_rdy && (rx_data == CMD_GO);
  assign stop_cmd = rx_rdy && (rx_data == CMD_STOP);

  // pwr_up is written alongside the state so it always mirrors PWR1/PWR2 membership.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auth_q   <= OFF;
      pwr_up_q <= 1'b0;
    end else begin
      case (auth_q)
        OFF: begin
          if (go_cmd) begin
            auth_q   <= PWR1;
            pwr_up_q <= 1'b1;
          end
        end
        PWR1: begin
          if (stop_cmd) begin
            if (rider_off) begin
              auth_q   <= OFF;
              pwr_up_q <= 1'b0;
            end else begin
              auth_q   <= PWR2;
              pwr_up_q <= 1'b1;
            end
          end
        end
        PWR2: begin
          // A fresh 'g' outranks a simultaneous rider_off.
          if (go_cmd) begin
            auth_q   <= PWR1;
            pwr_up_q <= 1'b1;
          end else if (rider_off) begin
            auth_q   <= OFF;
            pwr_up_q <= 1'b0;
          end
        end
        default: begin
          auth_q   <= OFF;
          pwr_up_q <= 1'b0;
        end
      endcase
    end
  end

  assign pwr_up = pwr_up_q;

endmodule

// File: tb/tb_ble_auth_rx.sv
// Scoreboard bench for ble_auth_rx: directed UART frames, monitor checks every rx_rdy/frm_err.
module tb_ble_auth_rx;

  localparam int BD = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       rider_off = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;
  logic       pwr_up;

  always #5 clk = ~clk;

  ble_auth_rx #(
    .BAUD_DIV(BD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rider_off(rider_off),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .frm_err  (frm_err),
    .pwr_up   (pwr_up)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       pwr_before;
    logic       pwr_after;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  logic chk_pend = 1'b0;
  logic chk_pwr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_evt(input logic is_err, input logic [7:0] d, input logic pb, input logic pa);
    exp_t e;
    e.is_err = is_err;
    e.data = d;
    e.pwr_before = pb;
    e.pwr_after = pa;
    sb.push_back(e);
  endtask

  // Drives start, 8 data bits LSB first and stop, BD cycles each, for len cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int len);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      RX = bits[c / BD];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      RX = 1'b1;
    end
  endtask

  // Monitor: pops one expectation per output pulse, then checks pwr_up on the following cycle.
  always @(negedge clk) begin
    if (chk_pend) begin
      check("pwr_up_after_event", pwr_up, chk_pwr);
      chk_pend = 1'b0;
    end
    if (rst_n && (rx_rdy || frm_err)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: rdy=%b err=%b data=%h expected no event (t=%0t)",
                 rx_rdy, frm_err, rx_data, $time);
      end else begin
        mon_e = sb.pop_front();
        $display("[TB] event rdy=%b err=%b data=%h pwr_up=%b", rx_rdy, frm_err, rx_data, pwr_up);
        check("event_kind", {30'd0, frm_err, rx_rdy}, mon_e.is_err ? 32'd2 : 32'd1);
        check("rx_data", rx_data, mon_e.data);
        check("pwr_up_at_event", pwr_up, mon_e.pwr_before);
        chk_pend = 1'b1;
        chk_pwr = mon_e.pwr_after;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_rdy", rx_rdy, 1'b0);
    check("reset_frm_err", frm_err, 1'b0);
    check("reset_pwr_up", pwr_up, 1'b0);
    rst_n = 1'b1;
    idle(BD);

    // 'g' powers up; 's' with rider present moves to PWR2.
    expect_evt(1'b0, 8'h67, 1'b0, 1'b1);
    send_frame(8'h67, 1'b1, 10 * BD);
    expect_evt(1'b0, 8'h73, 1'b1, 1'b1);
    send_frame(8'h73, 1'b1, 10 * BD);

    repeat (1000) @(negedge clk);
    check("pwr2_hold", pwr_up, 1'b1);
    rider_off = 1'b1;
    @(negedge clk);
    check("pwr2_rider_off", pwr_up, 1'b0);

    // Rider gone: 'g' still reaches PWR1, 's' then drops straight to OFF.
    expect_evt(1'b0, 8'h67, 1'b0, 1'b1);
    send_frame(8'h67, 1'b1, 10 * BD);
    expect_evt(1'b0, 8'h73, 1'b1, 1'b0);
    send_frame(8'h73, 1'b1, 10 * BD);
    expect_evt(1'b0, 8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 10 * BD);
    idle(BD);

    // Glitch shorter than half a bit is rejected as a false start.
    rider_off = 1'b0;
    repeat (BD / 4) begin
      @(negedge clk);
      RX = 1'b0;
    end
    idle(2 * BD);
    check("false_start_data_kept", rx_data, 8'hA5);
    expect_evt(1'b0, 8'h67, 1'b0, 1'b1);
    send_frame(8'h67, 1'b1, 10 * BD);

    rider_off = 1'b1;
    expect_evt(1'b0, 8'h73, 1'b1, 1'b0);
    send_frame(8'h73, 1'b1, 10 * BD);
    rider_off = 1'b0;

    // Stop bit low: frm_err only, rx_data keeps the previous byte.
    expect_evt(1'b1, 8'h73, 1'b0, 1'b0);
    send_frame(8'h67, 1'b0, 10 * BD);
    idle(2 * BD);
    check("frm_err_pwr_off", pwr_up, 1'b0);

    // Back-to-back frames with no idle gap.
    expect_evt(1'b0, 8'h67, 1'b0, 1'b1);
    send_frame(8'h67, 1'b1, 10 * BD);
    expect_evt(1'b0, 8'hA5, 1'b1, 1'b1);
    send_frame(8'hA5, 1'b1, 10 * BD);
    idle(BD);

    // Reset in the middle of data bit 4.
    send_frame(8'h67, 1'b1, 5 * BD + BD / 2);
    @(negedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    @(negedge clk);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_rdy", rx_rdy, 1'b0);
    check("midrst_frm_err", frm_err, 1'b0);
    check("midrst_pwr_up", pwr_up, 1'b0);
    rst_n = 1'b1;
    idle(2 * BD);
    check("midrst_no_event", rx_data, 8'h00);
    expect_evt(1'b0, 8'h67, 1'b0, 1'b1);
    send_frame(8'h67, 1'b1, 10 * BD);
    idle(2 * BD);

    for (int i = 0; i < 4 * BD && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_pwr_up", pwr_up, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ble_auth_rx.md
# ble_auth_rx

Receive-side endpoint of the BLE command link into the Segway. The block deserializes 8N1 UART frames arriving on the RX pin and decodes the go/stop command bytes into the registered `pwr_up` enable consumed by the balance controller and motor drive. It pairs with the existing `UART_tx`, which models the BLE module in the toplevel benches. It sits between the RX pad and the `pwr_up` consumers inside `Segway`.

## Interface
Parameters:
- `BAUD_DIV`, default 2604: clk cycles per bit (50 MHz / 19200 baud). Must be ≥ 16.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  synchronous, active-low reset, sampled on posedge `clk`.
- `RX`  in  1  asynchronous serial input, idle high.
- `rider_off`  in  1  high when load cells report no rider; synchronous to `clk`.
- `rx_data`  out  8  last correctly framed byte.
- `rx_rdy`  out  1  one-cycle pulse: `rx_data` was updated.
- `frm_err`  out  1  one-cycle pulse: stop bit sampled low.
- `pwr_up`  out  1  registered power enable.

## Operation
- RX passes through a 2-flop synchronizer. Both flops reset to 1 so no false start is seen after reset.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized falling edge (prev=1, cur=0) → START. Baud counter loads `BAUD_DIV/2` (integer divide).
  - START: when the counter expires, RX is sampled.
    - RX = 1 → false start, return to IDLE, no pulse.
    - RX = 0 → DATA, counter reloads `BAUD_DIV`, bit count = 0.
  - DATA: each expiry shifts RX into the MSB of the shift register, so data arrives LSB first. After the 8th sample → STOP.
  - STOP: on expiry RX is sampled.
    - RX = 1: `rx_data` ← shift register, `rx_rdy` pulses.
    - RX = 0: `frm_err` pulses and `rx_data` is unchanged.
    - Either way → IDLE. A new start can be detected the cycle after returning to IDLE.
- Baud counter: 12 bits, counts down, and expiry is at count 0.
- Auth FSM states: OFF, PWR1, PWR2. It acts only on `rx_rdy` bytes.
  - OFF: 8'h67 ('g') → PWR1.
  - PWR1: 8'h73 ('s') with `rider_off`=1 → OFF. 8'h73 with `rider_off`=0 → PWR2.
  - PWR2: `rider_off`=1 → OFF (checked every cycle). 8'h67 → PWR1.
  - All other bytes are ignored in every state.
  - Same-cycle 'g' and `rider_off`=1 in PWR2: 'g' wins → PWR1.
- `pwr_up` is registered and is 1 exactly while the auth FSM state is PWR1 or PWR2.

## Timing
- Reset values: `rx_data`=8'h00, `rx_rdy`=0, `frm_err`=0, `pwr_up`=0. Receiver FSM → IDLE, auth FSM → OFF.
- Reset mid-frame aborts the frame: no pulse, and the partial byte is discarded.
- Synchronizer latency is 2 cycles from the RX edge to the edge being detected.
- Sampling points are measured from the detect cycle T0:
  - Start bit sampled at T0 + `BAUD_DIV/2`.
  - Data bit k sampled at T0 + `BAUD_DIV/2` + (k+1)·`BAUD_DIV`.
  - Stop bit sampled at T0 + `BAUD_DIV/2` + 9·`BAUD_DIV`.
- `rx_rdy` / `frm_err` are high the cycle after the stop sample, for exactly 1 cycle.
- `pwr_up` changes the cycle after the `rx_rdy` pulse, or the cycle after `rider_off` rises while in PWR2.
- Back-to-back frames with zero idle time between them are received without loss.

## Structure
- `segway_pkg` holds:
  - `localparam CMD_GO = 8'h67`, `CMD_STOP = 8'h73`.
  - `typedef enum` `rx_state_t` {IDLE, START, DATA, STOP}.
  - `typedef enum` `auth_state_t` {OFF, PWR1, PWR2}.
- Sub-module `uart_rx` contains the synchronizer, baud counter, shift register and receiver FSM, and outputs `rx_data`, `rx_rdy` and `frm_err`.
- `ble_auth_rx` instantiates `uart_rx` and contains the auth FSM.

## Test plan
- Reset with RX=1, then send 8'h67 from `UART_tx` → `rx_rdy` pulses once, `rx_data`=8'h67, `pwr_up`=1 the next cycle.
- With `pwr_up`=1 and `rider_off`=0, send 8'h73 → `pwr_up` stays 1. Raise `rider_off` 1000 cycles later → `pwr_up`=0 one cycle later.
- With `pwr_up`=1 and `rider_off`=1, send 8'h73 → `pwr_up`=0 the cycle after `rx_rdy`. Then send 8'hA5 → `rx_data`=8'hA5, `pwr_up` stays 0.
- Drive RX low for `BAUD_DIV/4` cycles, then high → no `rx_rdy`, no `frm_err`. A following 8'h67 frame is received correctly.
- Force the stop bit low on an 8'h67 frame → `frm_err` pulses 1 cycle, no `rx_rdy`, `rx_data` unchanged, `pwr_up` stays 0.
- Assert `rst_n`=0 in the middle of bit 4 of a frame → all outputs 0 next cycle. After release, a clean 8'h67 → `pwr_up`=1.
